// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: queues ALU operations and issues them one at a time to a
// combinational ALU. Operands stay stable for SETTLE_CYC cycles, the result
// is captured and then offered on a valid/ready result port.
module alu_op_sequencer #(
  parameter int WIDTH      = 4,
  parameter int CMD_W      = 3,
  parameter int DEPTH      = 4,
  parameter int SETTLE_CYC = 1
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     req_valid_i,
  output logic                     req_ready_o,
  input  logic [WIDTH-1:0]         req_a_i,
  input  logic [WIDTH-1:0]         req_b_i,
  input  logic [CMD_W-1:0]         req_cmd_i,
  output logic [WIDTH-1:0]         alu_a_o,
  output logic [WIDTH-1:0]         alu_b_o,
  output logic [CMD_W-1:0]         alu_cmd_o,
  input  logic [WIDTH-1:0]         alu_res_i,
  output logic                     res_valid_o,
  input  logic                     res_ready_i,
  output logic [WIDTH-1:0]         res_data_o,
  output logic [CMD_W-1:0]         res_cmd_o,
  output logic                     busy_o,
  output logic [$clog2(DEPTH):0]   fifo_cnt_o,
  output logic [7:0]               ops_done_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int SW = $clog2(SETTLE_CYC + 1);

  typedef struct packed {
    logic [CMD_W-1:0] cmd;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] a;
  } op_t;

  typedef enum logic [1:0] {IDLE, SETTLE, HOLD} state_e;

  op_t              mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      cnt_q, cnt_d;
  logic             rdy_q;
  state_e           state_q, state_d;
  logic [SW-1:0]    set_q, set_d;
  op_t              alu_q, alu_d;
  logic [WIDTH-1:0] res_data_q, res_data_d;
  logic [CMD_W-1:0] res_cmd_q, res_cmd_d;
  logic             res_valid_q, res_valid_d;
  logic [7:0]       ops_q, ops_d;
  logic             push, pop;
  op_t              head;

  // rdy_q keeps req_ready low through reset and for the first edge after it
  assign req_ready_o = rdy_q & (cnt_q != (AW+1)'(DEPTH));
  assign push        = req_valid_i & req_ready_o;
  assign head        = mem_q[rd_ptr_q];

  assign alu_a_o     = alu_q.a;
  assign alu_b_o     = alu_q.b;
  assign alu_cmd_o   = alu_q.cmd;
  assign res_valid_o = res_valid_q;
  assign res_data_o  = res_data_q;
  assign res_cmd_o   = res_cmd_q;
  assign busy_o      = (state_q != IDLE) | (cnt_q != '0);
  assign fifo_cnt_o  = cnt_q;
  assign ops_done_o  = ops_q;

  // FIFO storage; contents are don't-care while empty so no reset needed
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= {req_cmd_i, req_b_i, req_a_i};
  end

  // Occupancy: simultaneous push and pop leave the count unchanged
  always_comb begin
    cnt_d = cnt_q;
    if (push && !pop)      cnt_d = cnt_q + (AW+1)'(1);
    else if (!push && pop) cnt_d = cnt_q - (AW+1)'(1);
  end

  // Issue FSM: next state, pops, operand drive and result capture
  always_comb begin
    state_d     = state_q;
    pop         = 1'b0;
    alu_d       = alu_q;
    set_d       = set_q;
    res_data_d  = res_data_q;
    res_cmd_d   = res_cmd_q;
    res_valid_d = res_valid_q;
    ops_d       = ops_q;
    case (state_q)
      IDLE: begin
        if (cnt_q != '0) begin
          pop     = 1'b1;
          alu_d   = head;
          set_d   = SW'(SETTLE_CYC);
          state_d = SETTLE;
        end
      end
      SETTLE: begin
        set_d = set_q - SW'(1);
        if (set_q == SW'(1)) begin
          res_data_d  = alu_res_i;
          res_cmd_d   = alu_q.cmd;
          res_valid_d = 1'b1;
          state_d     = HOLD;
        end
      end
      HOLD: begin
        if (res_ready_i) begin
          ops_d       = ops_q + 8'd1;
          res_valid_d = 1'b0;
          if (cnt_q != '0) begin
            // Chain straight into the next op without passing through IDLE
            pop     = 1'b1;
            alu_d   = head;
            set_d   = SW'(SETTLE_CYC);
            state_d = SETTLE;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset drops all queued and in-flight ops
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
      rdy_q       <= 1'b0;
      state_q     <= IDLE;
      set_q       <= '0;
      alu_q       <= '0;
      res_data_q  <= '0;
      res_cmd_q   <= '0;
      res_valid_q <= 1'b0;
      ops_q       <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      cnt_q       <= cnt_d;
      rdy_q       <= 1'b1;
      state_q     <= state_d;
      set_q       <= set_d;
      alu_q       <= alu_d;
      res_data_q  <= res_data_d;
      res_cmd_q   <= res_cmd_d;
      res_valid_q <= res_valid_d;
      ops_q       <= ops_d;
    end
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: two instances (SETTLE_CYC 1 and 3), each with
// its own combinational ALU, checked every cycle against a transaction-level
// model that derives issue/result timing from push and handoff edges.
module tb_alu_op_sequencer;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rv [2], rr [2];
  logic [3:0] ra [2], rb [2];
  logic [2:0] rc [2];
  logic       rdy [2], vld [2], bsy [2];
  logic [3:0] aa [2], ab [2], ares [2], rd [2];
  logic [2:0] ac [2], rcm [2], fc [2];
  logic [7:0] od [2];

  int cyc = 0, errors = 0, checks = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, cyc=%0d", cyc);
    $fatal(1);
  end

  // Reference ALU used both as the DUT's environment and by the model
  function automatic logic [3:0] alu_f(logic [3:0] a, logic [3:0] b, logic [2:0] c);
    case (c)
      3'd0:    return a + b;
      3'd1:    return a - b;
      3'd2:    return a & b;
      3'd3:    return a | b;
      3'd4:    return a ^ b;
      3'd5:    return ~a;
      3'd6:    return a << 1;
      default: return b;
    endcase
  endfunction

  assign ares[0] = alu_f(aa[0], ab[0], ac[0]);
  assign ares[1] = alu_f(aa[1], ab[1], ac[1]);

  alu_op_sequencer #(.WIDTH(4), .CMD_W(3), .DEPTH(4), .SETTLE_CYC(1)) u0 (
    .clk_i(clk), .rst_ni(rst_n), .req_valid_i(rv[0]), .req_ready_o(rdy[0]),
    .req_a_i(ra[0]), .req_b_i(rb[0]), .req_cmd_i(rc[0]),
    .alu_a_o(aa[0]), .alu_b_o(ab[0]), .alu_cmd_o(ac[0]), .alu_res_i(ares[0]),
    .res_valid_o(vld[0]), .res_ready_i(rr[0]), .res_data_o(rd[0]), .res_cmd_o(rcm[0]),
    .busy_o(bsy[0]), .fifo_cnt_o(fc[0]), .ops_done_o(od[0]));

  alu_op_sequencer #(.WIDTH(4), .CMD_W(3), .DEPTH(4), .SETTLE_CYC(3)) u1 (
    .clk_i(clk), .rst_ni(rst_n), .req_valid_i(rv[1]), .req_ready_o(rdy[1]),
    .req_a_i(ra[1]), .req_b_i(rb[1]), .req_cmd_i(rc[1]),
    .alu_a_o(aa[1]), .alu_b_o(ab[1]), .alu_cmd_o(ac[1]), .alu_res_i(ares[1]),
    .res_valid_o(vld[1]), .res_ready_i(rr[1]), .res_data_o(rd[1]), .res_cmd_o(rcm[1]),
    .busy_o(bsy[1]), .fifo_cnt_o(fc[1]), .ops_done_o(od[1]));

  task automatic chk(string nm, int i, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s inst%0d cyc=%0d got=%0h exp=%0h", nm, i, cyc, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Each accepted op remembers its push edge. The head op is issued at the
  // handoff edge of its predecessor if it was already queued then, otherwise
  // one edge after its own push; its result is valid SETTLE_CYC edges later.
  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [2:0] c;
    int         pe;
  } op_t;

  op_t        mq [2][64];
  int         mh [2], mt [2], lh [2], mops [2];
  bit         mrdy [2];
  logic [3:0] la [2], lb [2];
  logic [2:0] lc [2];

  always @(negedge clk) begin
    op_t hd;
    int  sz, iss_at, scv, cexp;
    bit  iss, vexp, rexp;
    for (int i = 0; i < 2; i++) begin
      scv = (i == 0) ? 1 : 3;
      if (!rst_n) begin
        chk("reset_outs", i, {rdy[i], aa[i], ab[i], ac[i], vld[i], rd[i], rcm[i], bsy[i], fc[i], od[i]}, 32'd0);
        mh[i] = 0; mt[i] = 0; lh[i] = -1000; mops[i] = 0; mrdy[i] = 1'b0;
        la[i] = '0; lb[i] = '0; lc[i] = '0;
      end else begin
        sz   = mt[i] - mh[i];
        hd   = mq[i][mh[i] % 64];
        iss  = 1'b0;
        vexp = 1'b0;
        if (sz > 0) begin
          iss_at = (hd.pe < lh[i]) ? lh[i] : hd.pe + 1;
          iss    = (cyc >= iss_at);
          vexp   = (cyc >= iss_at + scv);
        end
        cexp = sz - (iss ? 1 : 0);
        rexp = mrdy[i] && (cexp < 4);
        chk("req_ready", i, rdy[i], rexp);
        chk("fifo_cnt", i, fc[i], cexp);
        chk("busy", i, bsy[i], sz > 0);
        chk("ops_done", i, od[i], mops[i]);
        chk("res_valid", i, vld[i], vexp);
        if (iss) chk("alu_drive", i, {aa[i], ab[i], ac[i]}, {hd.a, hd.b, hd.c});
        else     chk("alu_drive", i, {aa[i], ab[i], ac[i]}, {la[i], lb[i], lc[i]});
        if (vexp) begin
          chk("res_data", i, rd[i], alu_f(hd.a, hd.b, hd.c));
          chk("res_cmd", i, rcm[i], hd.c);
        end
        if (vexp && rr[i]) begin
          la[i] = hd.a; lb[i] = hd.b; lc[i] = hd.c;
          lh[i] = cyc + 1;
          mh[i]++;
          mops[i] = (mops[i] + 1) % 256;
        end
        if (rv[i] && rexp) begin
          mq[i][mt[i] % 64] = '{a: ra[i], b: rb[i], c: rc[i], pe: cyc + 1};
          mt[i]++;
        end
        mrdy[i] = 1'b1;
      end
    end
  end

  // ---------------- stimulus ----------------
  // Called #1 after a rising edge; returns #1 after the accepting edge
  task automatic push_op(int i, logic [3:0] a, logic [3:0] b, logic [2:0] c);
    int w = 0;
    rv[i] = 1'b1; ra[i] = a; rb[i] = b; rc[i] = c;
    while (!rdy[i] && w < 300) begin
      @(posedge clk); #1;
      w++;
    end
    chk("push_within_bound", i, w < 300, 1);
    @(posedge clk); #1;
    rv[i] = 1'b0;
  endtask

  task automatic wait_cyc(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic rand_run(int i, int n);
    bit done = 1'b0;
    fork
      begin
        for (int k = 0; k < n; k++) begin
          repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
          push_op(i, 4'($urandom), 4'($urandom), 3'($urandom));
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          rr[i] = ($urandom_range(0, 3) != 0);
          @(posedge clk); #1;
        end
      end
    join
  endtask

  initial begin
    int got [4];
    int tim [4];
    int nres;
    for (int i = 0; i < 2; i++) begin
      rv[i] = 1'b0; rr[i] = 1'b0; ra[i] = '0; rb[i] = '0; rc[i] = '0;
    end
    rst_n = 1'b0;
    wait_cyc(3);
    rst_n = 1'b1;
    wait_cyc(1);
    chk("ready_after_rst", 0, rdy[0], 1);
    chk("cnt_after_rst", 0, fc[0], 0);

    // single op into idle block: 10 - 1 = 9
    rr[0] = 1'b1;
    push_op(0, 4'd10, 4'd1, 3'd1);
    wait_cyc(1);
    chk("single_alu", 0, {aa[0], ab[0], ac[0]}, {4'd10, 4'd1, 3'd1});
    chk("single_vld_early", 0, vld[0], 0);
    wait_cyc(1);
    chk("single_vld", 0, vld[0], 1);
    chk("single_data", 0, rd[0], 9);
    chk("single_cmd", 0, rcm[0], 1);
    wait_cyc(1);
    chk("single_ops", 0, od[0], 1);

    // stream of four with res_ready held high
    nres = 0;
    fork
      begin
        push_op(0, 4'd11, 4'(21), 3'd3);
        push_op(0, 4'd11, 4'd5,   3'd4);
        push_op(0, 4'd15, 4'd5,   3'd6);
        push_op(0, 4'd15, 4'd12,  3'd5);
      end
      begin
        for (int k = 0; k < 20; k++) begin
          @(posedge clk); #1;
          if (vld[0] && rr[0] && nres < 4) begin
            got[nres] = int'(rd[0]);
            tim[nres] = cyc;
            nres++;
          end
        end
      end
    join
    chk("stream_count", 0, nres, 4);
    chk("stream_r0", 0, got[0], 15);
    chk("stream_r1", 0, got[1], 14);
    chk("stream_r2", 0, got[2], 14);
    chk("stream_r3", 0, got[3], 0);
    for (int k = 1; k < 4; k++) chk("stream_gap", 0, tim[k] - tim[k-1], 2);
    chk("stream_ops", 0, od[0], 5);

    // back-pressure: six pushes with the consumer stalled
    rr[0] = 1'b0;
    fork
      begin
        for (int k = 0; k < 6; k++) push_op(0, 4'(3 + k), 4'(k), 3'(k));
      end
      begin
        wait_cyc(12);
        chk("bp_cnt_full", 0, fc[0], 4);
        chk("bp_not_ready", 0, rdy[0], 0);
        chk("bp_vld", 0, vld[0], 1);
        chk("bp_data_held", 0, rd[0], 3);
        rr[0] = 1'b1;
      end
    join
    wait_cyc(20);
    chk("bp_ops", 0, od[0], 11);

    // simultaneous push and pop at occupancy 2
    rr[0] = 1'b0;
    push_op(0, 4'd1, 4'd1, 3'd0);
    push_op(0, 4'd2, 4'd1, 3'd0);
    push_op(0, 4'd3, 4'd1, 3'd0);
    rr[0] = 1'b1;
    push_op(0, 4'd4, 4'd1, 3'd0);
    rr[0] = 1'b0;
    chk("pushpop_cnt", 0, fc[0], 2);
    chk("pushpop_issued", 0, aa[0], 2);
    rr[0] = 1'b1;
    wait_cyc(15);
    chk("pushpop_ops", 0, od[0], 15);

    // reset in SETTLE with three ops queued
    rr[0] = 1'b0;
    for (int k = 0; k < 4; k++) push_op(0, 4'(k + 5), 4'd2, 3'd2);
    rr[0] = 1'b1;
    push_op(0, 4'd9, 4'd9, 3'd4);
    rr[0] = 1'b0;
    chk("pre_rst_cnt", 0, fc[0], 3);
    chk("pre_rst_settle", 0, vld[0], 0);
    rst_n = 1'b0;
    #1;
    chk("rst_cnt", 0, fc[0], 0);
    chk("rst_vld", 0, vld[0], 0);
    chk("rst_alu", 0, {aa[0], ab[0], ac[0]}, 0);
    chk("rst_ops", 0, od[0], 0);
    chk("rst_ready", 0, rdy[0], 0);
    wait_cyc(2);
    rst_n = 1'b1;
    rr[0] = 1'b1;
    wait_cyc(5);
    chk("post_rst_vld", 0, vld[0], 0);
    chk("post_rst_busy", 0, bsy[0], 0);
    chk("post_rst_ready", 0, rdy[0], 1);

    // ops_done wrap after 256 handoffs
    for (int k = 0; k < 255; k++) push_op(0, 4'($urandom), 4'($urandom), 3'($urandom));
    wait_cyc(20);
    chk("ops_255", 0, od[0], 255);
    push_op(0, 4'd7, 4'd7, 3'd0);
    wait_cyc(10);
    chk("ops_wrap", 0, od[0], 0);

    // SETTLE_CYC=3 instance: operands held three cycles, result on the fifth
    rr[1] = 1'b1;
    push_op(1, 4'd6, 4'd3, 3'd0);
    for (int k = 1; k <= 4; k++) begin
      wait_cyc(1);
      chk("s3_alu_stable", 1, {aa[1], ab[1], ac[1]}, {4'd6, 4'd3, 3'd0});
      chk("s3_vld_timing", 1, vld[1], k == 4);
    end
    chk("s3_data", 1, rd[1], 9);
    wait_cyc(3);

    // randomized traffic on both instances
    fork
      rand_run(0, 150);
      rand_run(1, 150);
    join
    rr[0] = 1'b1;
    rr[1] = 1'b1;
    wait_cyc(40);
    chk("drain_idle0", 0, bsy[0], 0);
    chk("drain_idle1", 1, bsy[1], 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
